// File: rtl/stim_pattern_pkg.sv
// Shared encodings and the next-word function for the stimulus pattern generator.
// Words are handled at PAT_MAX_W bits inside the function; callers narrow the result to WIDTH (WIDTH <= 32).
package stim_pattern_pkg;

  localparam int unsigned PAT_MAX_W = 32;

  typedef logic [PAT_MAX_W-1:0] pat_word_t;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_WALK1 = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits at and above 'width' in the result are don't-care; the caller truncates.
  function automatic pat_word_t next_word(input mode_e mode, input pat_word_t word,
                                          input pat_word_t taps, input int unsigned width);
    pat_word_t res;
    res = word;
    case (mode)
      MODE_COUNT: res = word + pat_word_t'(1);
      MODE_WALK1: res = (word << 1) | pat_word_t'(word[width-1]);
      MODE_LFSR:  res = word[0] ? ((word >> 1) ^ taps) : (word >> 1);
      default:    res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/stim_pattern_step.sv
// Combinational next-word generator: applies one pattern step to the current word.
module stim_pattern_step
  import stim_pattern_pkg::*;
#(
  parameter int unsigned       WIDTH = 3,
  parameter logic [WIDTH-1:0]  TAPS  = 3'b110
) (
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_word,
  output logic [WIDTH-1:0] o_next
);

  assign o_next = WIDTH'(next_word(mode_e'(i_mode), pat_word_t'(i_word),
                                   pat_word_t'(TAPS), WIDTH));

endmodule

// File: rtl/stim_pattern_gen.sv
// Programmable operand pattern source with valid/ready output and start/done control.
// Optional build macro STIM_PAT_CHECKSUM_EN adds a running sum of accepted words on port checksum.
module stim_pattern_gen
  import stim_pattern_pkg::*;
#(
  parameter int unsigned      WIDTH = 3,
  parameter int unsigned      LEN_W = 8,
  parameter logic [WIDTH-1:0] TAPS  = 3'b110
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       o_dbg_state
`ifdef STIM_PAT_CHECKSUM_EN
  ,
  output logic [WIDTH+LEN_W-1:0] checksum
`endif
);

  // Output handshake: a word transfers on a rising edge where out_valid & out_ready;
  // out_data never changes while out_valid is high and out_ready is low.

  state_e           r_state;
  state_e           w_state_nxt;
  logic [1:0]       r_mode;
  logic [LEN_W-1:0] r_len_left;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_step_word;
  logic [WIDTH-1:0] w_first_word;
  logic             w_start_acc;
  logic             w_beat_acc;
  logic             w_last_beat;
  mode_e            w_mode_in;

  assign w_mode_in   = mode_e'(mode);
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_beat_acc  = (r_state == ST_RUN) && out_ready;
  assign w_last_beat = w_beat_acc && (r_len_left == LEN_W'(1));

  // An all-zero seed would lock the LFSR and leave WALK1 with no bit to walk.
  always_comb begin
    w_first_word = seed;
    if ((seed == '0) && ((w_mode_in == MODE_LFSR) || (w_mode_in == MODE_WALK1)))
      w_first_word = WIDTH'(1);
  end

  stim_pattern_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .i_mode (r_mode),
    .i_word (r_word),
    .o_next (w_step_word)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_acc) w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last_beat) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_data    = r_word;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_mode     <= '0;
      r_len_left <= '0;
      r_word     <= '0;
    end else if (w_start_acc) begin
      r_mode     <= mode;
      r_len_left <= len;
      r_word     <= w_first_word;
    end else if (w_beat_acc) begin
      r_len_left <= r_len_left - LEN_W'(1);
      r_word     <= w_step_word;
    end
  end

`ifdef STIM_PAT_CHECKSUM_EN
  logic [WIDTH+LEN_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)          r_checksum <= '0;
    else if (w_start_acc) r_checksum <= '0;
    else if (w_beat_acc)  r_checksum <= r_checksum + (WIDTH+LEN_W)'(r_word);
  end

  assign checksum = r_checksum;
`else
  // No accumulator in this build.
`endif

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Directed bench for stim_pattern_gen with a scoreboard of expected accepted words.
module tb_stim_pattern_gen;

  localparam int WIDTH = 3;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             resetb = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       mode = '0;
  logic [WIDTH-1:0] seed = '0;
  logic [LEN_W-1:0] len = '0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [1:0]       o_dbg_state;
`ifdef STIM_PAT_CHECKSUM_EN
  logic [WIDTH+LEN_W-1:0] checksum;
`endif

  logic [WIDTH-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail = 0;
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] stall_data = '0;

  stim_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TAPS(3'b110)) dut (
    .clk         (clk),
    .resetb      (resetb),
    .start       (start),
    .mode        (mode),
    .seed        (seed),
    .len         (len),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (o_dbg_state)
`ifdef STIM_PAT_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted word is popped and compared; stalled words must hold.
  always @(negedge clk) begin
    if (resetb) begin
      if (stall_prev) chk("stall_hold", 32'(out_data), 32'(stall_data));
      if (out_valid && out_ready) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_beat: observed word %0h with no expected word queued", out_data);
        end
        if (exp_q.size() != 0) chk("beat", 32'(out_data), 32'(exp_q.pop_front()));
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Inputs are scrambled after capture; the DUT must ignore them while busy.
  task automatic start_seq(input logic [1:0] m, input logic [WIDTH-1:0] s, input logic [LEN_W-1:0] l);
    mode  = m;
    seed  = s;
    len   = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    seed  = WIDTH'($urandom_range(0, 7));
    len   = LEN_W'($urandom_range(0, 255));
  endtask

  // Cycle 1 is the cycle right after the start edge; returns in the cycle after done.
  task automatic wait_done(input string tag, input int exp_cyc, input bit tog);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        if (tog) out_ready = ~out_ready;
      end
    end
    chk({tag, "_done_cycle"}, seen ? 32'(cyc) : 32'hdead, 32'(exp_cyc));
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_q_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2 resetb = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // COUNT, seed 1, len 7, always ready
    for (int i = 1; i <= 7; i++) exp_q.push_back(WIDTH'(i));
    start_seq(2'd0, 3'd1, 8'd7);
    wait_done("count7", 8, 1'b0);

    // WALK1, seed 0, len 4, ready toggling 1,0,1,0
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    out_ready = 1'b1;
    start_seq(2'd1, 3'd0, 8'd4);
    wait_done("walk4", 8, 1'b1);
    out_ready = 1'b1;

    // LFSR, seed 1, len 7 then len 8
    exp_q = '{3'd1, 3'd6, 3'd3, 3'd7, 3'd5, 3'd4, 3'd2};
    start_seq(2'd2, 3'd1, 8'd7);
    wait_done("lfsr7", 8, 1'b0);
    exp_q = '{3'd1, 3'd6, 3'd3, 3'd7, 3'd5, 3'd4, 3'd2, 3'd1};
    start_seq(2'd2, 3'd1, 8'd8);
    wait_done("lfsr8", 9, 1'b0);

    // LFSR zero seed substitutes 1; HOLD repeats seed
    exp_q = '{3'd1, 3'd6};
    start_seq(2'd2, 3'd0, 8'd2);
    wait_done("lfsr_seed0", 3, 1'b0);
    exp_q = '{3'd5, 3'd5, 3'd5};
    start_seq(2'd3, 3'd5, 8'd3);
    wait_done("hold3", 4, 1'b0);

    // len 0: no beats, done next cycle, start during DONE ignored, next IDLE start accepted
    start_seq(2'd0, 3'd2, 8'd0);
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_valid", 32'(out_valid), 32'd0);
    mode  = 2'd0;
    seed  = 3'd5;
    len   = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_start_ignored_busy", 32'(busy), 32'd0);
    chk("done_start_ignored_state", 32'(o_dbg_state), 32'd0);
    exp_q = '{3'd5, 3'd6};
    start_seq(2'd0, 3'd5, 8'd2);
    wait_done("after_len0", 3, 1'b0);

    // Asynchronous reset mid-sequence
    exp_q = '{3'd6, 3'd7};
    start_seq(2'd0, 3'd6, 8'd5);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 resetb = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_data", 32'(out_data), 32'd0);
    chk("abort_q_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done_rst", 32'(done), 32'd0);
    end
    resetb = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done_after", 32'(done), 32'd0);
      chk("abort_idle_after", 32'(busy), 32'd0);
    end
    exp_q = '{3'd3, 3'd4, 3'd5};
    start_seq(2'd0, 3'd3, 8'd3);
    wait_done("after_abort", 4, 1'b0);

`ifdef STIM_PAT_CHECKSUM_EN
    for (int i = 1; i <= 7; i++) exp_q.push_back(WIDTH'(i));
    start_seq(2'd0, 3'd1, 8'd7);
    wait_done("csum_count7", 8, 1'b0);
    chk("csum_28", 32'(checksum), 32'd28);
    @(negedge clk);
    chk("csum_held", 32'(checksum), 32'd28);
    exp_q.push_back(3'd2);
    start_seq(2'd3, 3'd2, 8'd1);
    chk("csum_cleared", 32'(checksum), 32'd0);
    wait_done("csum_hold1", 2, 1'b0);
    chk("csum_2", 32'(checksum), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stim_pattern_gen.md
Name: stim_pattern_gen

Overview:
Synthesizable, parametrised pattern source that drives datapath operands (e.g. adder inputs) in tutorial designs and on-FPGA self-test. Generalises the fixed 3-bit post-reset input walk into a programmable generator. It has WIDTH-bit words, four pattern modes, a programmable beat count, a valid/ready output handshake and a start/done control handshake. It sits between a test controller (or host registers) and the DUT operand ports.

Parameters:
WIDTH, 3, output word width (>=2)
LEN_W, 8, width of beat-count input
TAPS, 3'b110, Galois LFSR feedback mask (WIDTH bits; bit i set = tap at bit i)

Ports:
clk  input  1  rising-edge clock
resetb  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sequence; sampled only in IDLE
mode  input  2  0=COUNT, 1=WALK1, 2=LFSR, 3=HOLD; captured with start
seed  input  WIDTH  first word of sequence; captured with start
len  input  LEN_W  number of beats to emit; captured with start
out_data  output  WIDTH  current pattern word
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts word when out_valid & out_ready
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (resetb=0, asynchronous): state=IDLE; out_data=0, out_valid=0, busy=0, done=0; internal mode/len/count registers cleared. Reset mid-sequence aborts immediately with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge T captures mode, seed and len.
  - len!=0: go to RUN. out_valid=1 and out_data=first word from cycle T+1.
  - len==0: go directly to DONE. done=1 in cycle T+1. No beat is emitted.
- First word: seed, except LFSR with seed==0 uses 1 (lock-up avoidance) and WALK1 with seed==0 uses 1.
- RUN: out_data is held stable while out_valid & !out_ready. Stalls have no limit.
- On each accepted beat, the remaining-beat counter decrements, and next word loads on the same edge:
  - COUNT: word+1, wraps from 2^WIDTH-1 to 0.
  - WALK1: rotate left by 1, MSB wraps into bit0.
  - LFSR: Galois step: lsb=word[0]; word=word>>1; if lsb then word ^= TAPS.
  - HOLD: unchanged.
- Last beat accepted (remaining==1) at edge K: out_valid=0 and go to DONE from K+1. done=1 for exactly cycle K+1.
- DONE: lasts exactly one cycle, then IDLE. busy drops at K+2.
- Any start pulse in RUN or DONE is ignored, with no queuing. A start in the first IDLE cycle (K+2) is accepted.
- mode, seed and len changes while busy have no effect.
- Throughput: one word per cycle with out_ready held high. Latency start→first valid is 1 cycle.
- len counts up to 2^LEN_W-1 beats. Wrap-around of words is permitted within a sequence.

Optional Feature:
STIM_PAT_CHECKSUM_EN
- Defined: adds output port checksum [WIDTH+LEN_W-1:0]. It is cleared when start is accepted and accumulates the unsigned sum of every accepted out_data. It is stable from the done cycle until the next accepted start, and reset to 0.
- Undefined: the port and adder are absent. All other behaviour is identical.

Decomposition:
- Package stim_pattern_pkg holds:
  - mode encodings MODE_COUNT/MODE_WALK1/MODE_LFSR/MODE_HOLD
  - state encodings ST_IDLE/ST_RUN/ST_DONE
  - a function next_word(mode, word, TAPS)
- One natural sub-module: stim_pattern_step. It is a combinational next-word generator (mode, word → next word) and is instantiated once. The FSM, counter and handshake stay in the top.

Test Plan:
- WIDTH=3, mode=COUNT, seed=1, len=7, out_ready=1: out_data 1,2,3,4,5,6,7 on 7 consecutive cycles starting T+1. done=1 on cycle T+8 only. busy low from T+9.
- WIDTH=3, WALK1, seed=0, len=4, out_ready toggling 1,0,1,0…: accepted words are 001,010,100,001. Each word is held through its stalled cycle, and done follows the 4th acceptance by 1 cycle.
- WIDTH=3, LFSR, TAPS=3'b110, seed=1, len=7, ready=1: words 1,6,3,7,5,4,2 (all 7 nonzero values). With len=8 the 8th word returns to 1.
- len=0, COUNT: no out_valid at all. done=1 exactly one cycle after start. A second start during DONE is ignored; a start on the following IDLE cycle begins a new sequence.
- Mid-sequence: COUNT seed=6, len=5. After 2 accepted words, assert resetb=0 asynchronously between edges. out_valid, busy and out_data go to 0 immediately. No done pulse follows, and after release a new start runs normally.
- With STIM_PAT_CHECKSUM_EN, COUNT seed=1, len=7, WIDTH=3: checksum=28 at the done cycle. It is held at 28 until the next start, then cleared.
